mu0_control: RTL and testbench
==============================

Name: mu0_control

Overview:
- Control unit for the MU0 16-bit processor; sequences the datapath, register file enables, memory interface and 4-mode ALU.
- Two-phase fetch/execute FSM with a halt state; stalls on a memory-ready handshake.
- Counts retired instructions for debug and test.
- Sits beside the datapath in the MU0 top level; consumes IR opcode and accumulator flags.

Parameters:
CNT_W, 16, width of retired-instruction counter InstrCount

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
F  in  4  opcode, IR[15:12]
N  in  1  accumulator negative flag, Acc[15]
Z  in  1  accumulator zero flag, Acc==0
MemReady  in  1  memory completes the current access this cycle
XSel  out  1  ALU X source: 0=Acc, 1=PC
YSel  out  1  ALU Y source: 0=memory data, 1=IR[11:0] zero-extended
AddrSel  out  1  memory address: 0=PC, 1=IR[11:0]
M  out  2  ALU mode: 00 Q=Y, 01 Q=X+Y, 10 Q=X+1, 11 Q=X-Y
AccCe  out  1  Acc load enable
PcCe  out  1  PC load enable
IrCe  out  1  IR load enable
AccOe  out  1  Acc drives memory write data
MemRq  out  1  memory request
RnW  out  1  1=read, 0=write
Fetch  out  1  high in FETCH state
Halted  out  1  high in HALT state
InstrCount  out  CNT_W  retired instructions, saturating

Behaviour:
- States: FETCH, EXEC, HALT. Reset asynchronously forces FETCH and InstrCount=0.
- While Reset is high, every output is 0 (including Fetch); outputs are combinational from state, F, N, Z and MemReady.
- FETCH:
  - AddrSel=0, MemRq=1, RnW=1, XSel=1, M=10.
  - Load enables IrCe=PcCe=1 only when MemReady=1; then go to EXEC.
  - MemReady=0: enables 0, stay in FETCH, request held stable.
- EXEC, memory opcodes (AddrSel=1, MemRq=1):
  - LDA 0: RnW=1, YSel=0, M=00, AccCe.
  - STA 1: RnW=0, AccOe=1.
  - ADD 2: RnW=1, XSel=0, YSel=0, M=01, AccCe.
  - SUB 3: same as ADD with M=11.
  - AccCe asserts only when MemReady=1. On MemReady=0, stay in EXEC with all enables 0; MemRq, RnW and AccOe remain asserted.
  - On MemReady=1, go to FETCH and retire.
- EXEC, non-memory opcodes (MemRq=0; MemReady ignored):
  - Each takes one cycle, then FETCH and retire.
  - JMP 4: YSel=1, M=00, PcCe=1.
  - JGE 5: as JMP if N=0, else no enables.
  - JNE 6: as JMP if Z=0, else no enables.
- STP 7: no enables; go to HALT and retire.
- Opcodes 8–15: NOP; no enables; one cycle, then FETCH and retire.
- HALT: all enables and MemRq 0, Halted=1. Exit only via Reset.
- Retire: InstrCount increments on the clock edge leaving EXEC; saturates at all-ones (no wrap).
- Latency with zero wait states: 2 cycles per instruction; each MemReady=0 cycle adds 1.
- Flags N, Z are sampled in the EXEC cycle, not at fetch.
- Reset mid-access: MemRq drops immediately (asynchronous); no partial register load occurs.
- Unused select outputs default to 0 in every state.

Decomposition:
- Shared package mu0_pkg: opcode constants (OP_LDA..OP_STP), ALU mode constants (ALU_PASSY=00, ALU_ADD=01, ALU_INC=10, ALU_SUB=11), state enum (S_FETCH, S_EXEC, S_HALT).
- One natural sub-module: mu0_decode, a purely combinational EXEC-state decode of F/N/Z to the control vector. The FSM, stall gating and counter stay in mu0_control.

Test Plan:
- Reset then MemReady=1, F=0 (LDA) -> cycle 1: Fetch=1, IrCe=PcCe=1, M=10; cycle 2: AddrSel=1, M=00, AccCe=1; InstrCount=1.
- FETCH with MemReady low for 3 cycles -> MemRq=1, IrCe=PcCe=0 for 3 cycles, load on 4th; STA then write with RnW=0, AccOe=1.
- F=5 with N=1 -> EXEC has PcCe=0; F=5 with N=0 -> PcCe=1, YSel=1, M=00. Same pair for F=6 with Z.
- F=3 (SUB) with MemReady=1 -> M=11, XSel=0, YSel=0, AccCe=1; F=9 -> all enables 0, returns to FETCH, InstrCount increments.
- F=7 -> Halted=1 next cycle, all enables 0 for 20 cycles regardless of F or MemReady; pulse Reset -> Fetch=1, InstrCount=0.
- Reset asserted mid-EXEC of LDA with MemReady=0 -> MemRq and AccCe drop to 0 in the same cycle; CNT_W=4 run of 20 NOPs -> InstrCount holds at 15.

Source files
------------

// File: rtl/mu0_pkg.sv
// Shared opcode, ALU-mode and state definitions for the MU0 control unit.
// Also carries the packed control vector passed from the decoder to the FSM.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    localparam logic [1:0] ALU_PASSY = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_INC   = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       xsel;
        logic       ysel;
        logic       addr_sel;
        logic [1:0] m;
        logic       acc_ce;
        logic       pc_ce;
        logic       acc_oe;
        logic       mem_rq;
        logic       rnw;
        logic       halt;
    } ctrl_t;

    // Opcodes 0..3 touch memory in EXEC and therefore wait on MemReady.
    function automatic logic is_mem_op(input logic [3:0] f);
        return (f[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// EXEC-state decode of opcode and accumulator flags into the raw control vector.
// Purely combinational; stall gating on MemReady is applied by the caller.
module mu0_decode
    import mu0_pkg::*;
(
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output ctrl_t      ctrl
);

    logic take_jump;

    always_comb begin
        take_jump = 1'b0;
        ctrl      = '0;
        case (F)
            OP_LDA: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_rq   = 1'b1;
                ctrl.rnw      = 1'b1;
                ctrl.m        = ALU_PASSY;
                ctrl.acc_ce   = 1'b1;
            end
            OP_STA: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_rq   = 1'b1;
                ctrl.acc_oe   = 1'b1;
            end
            OP_ADD: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_rq   = 1'b1;
                ctrl.rnw      = 1'b1;
                ctrl.m        = ALU_ADD;
                ctrl.acc_ce   = 1'b1;
            end
            OP_SUB: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_rq   = 1'b1;
                ctrl.rnw      = 1'b1;
                ctrl.m        = ALU_SUB;
                ctrl.acc_ce   = 1'b1;
            end
            OP_JMP:  take_jump = 1'b1;
            OP_JGE:  take_jump = ~N;
            OP_JNE:  take_jump = ~Z;
            OP_STP:  ctrl.halt = 1'b1;
            default: ctrl = '0;
        endcase

        // A not-taken branch leaves its selects at 0 as well as its enables.
        if (take_jump) begin
            ctrl.ysel  = 1'b1;
            ctrl.m     = ALU_PASSY;
            ctrl.pc_ce = 1'b1;
        end
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer with halt state and saturating retired-instruction count.
// Two cycles per instruction; each MemReady=0 cycle on a memory access stalls one cycle.
module mu0_control
    import mu0_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       F,
    input  logic             N,
    input  logic             Z,
    input  logic             MemReady,
    output logic             XSel,
    output logic             YSel,
    output logic             AddrSel,
    output logic [1:0]       M,
    output logic             AccCe,
    output logic             PcCe,
    output logic             IrCe,
    output logic             AccOe,
    output logic             MemRq,
    output logic             RnW,
    output logic             Fetch,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            dec;
    logic             exec_done;

    mu0_decode u_decode (
        .F    (F),
        .N    (N),
        .Z    (Z),
        .ctrl (dec)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exec_done = 1'b0;
        XSel      = 1'b0;
        YSel      = 1'b0;
        AddrSel   = 1'b0;
        M         = 2'b00;
        AccCe     = 1'b0;
        PcCe      = 1'b0;
        IrCe      = 1'b0;
        AccOe     = 1'b0;
        MemRq     = 1'b0;
        RnW       = 1'b0;
        Fetch     = 1'b0;
        Halted    = 1'b0;

        // Gating on Reset drops any in-flight request without waiting for the flops.
        if (!Reset) begin
            case (state_q)
                S_FETCH: begin
                    Fetch = 1'b1;
                    XSel  = 1'b1;
                    M     = ALU_INC;
                    MemRq = 1'b1;
                    RnW   = 1'b1;
                    IrCe  = MemReady;
                    PcCe  = MemReady;
                    if (MemReady) begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    XSel    = dec.xsel;
                    YSel    = dec.ysel;
                    AddrSel = dec.addr_sel;
                    M       = dec.m;
                    MemRq   = dec.mem_rq;
                    RnW     = dec.rnw;
                    AccOe   = dec.acc_oe;
                    PcCe    = dec.pc_ce;
                    AccCe   = dec.acc_ce & MemReady;
                    exec_done = ~is_mem_op(F) | MemReady;
                    if (exec_done) begin
                        state_d = dec.halt ? S_HALT : S_FETCH;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    Halted = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mu0_control.sv
// Randomised instruction-level check of mu0_control against a per-instruction reference model.
// A second CNT_W=4 instance shares all inputs to exercise counter saturation.
module tb_mu0_control;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  F;
    logic        N, Z, MemReady;
    logic        XSel, YSel, AddrSel, AccCe, PcCe, IrCe, AccOe, MemRq, RnW, Fetch, Halted;
    logic [1:0]  M;
    logic [15:0] InstrCount;
    logic        s_XSel, s_YSel, s_AddrSel, s_AccCe, s_PcCe, s_IrCe, s_AccOe, s_MemRq, s_RnW;
    logic        s_Fetch, s_Halted;
    logic [1:0]  s_M;
    logic [3:0]  s_InstrCount;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    localparam int PH_F = 0;
    localparam int PH_E = 1;
    localparam int PH_H = 2;

    always #5 Clk = ~Clk;

    mu0_control #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemReady(MemReady),
        .XSel(XSel), .YSel(YSel), .AddrSel(AddrSel), .M(M), .AccCe(AccCe), .PcCe(PcCe),
        .IrCe(IrCe), .AccOe(AccOe), .MemRq(MemRq), .RnW(RnW), .Fetch(Fetch),
        .Halted(Halted), .InstrCount(InstrCount)
    );

    mu0_control #(.CNT_W(4)) dut_small (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemReady(MemReady),
        .XSel(s_XSel), .YSel(s_YSel), .AddrSel(s_AddrSel), .M(s_M), .AccCe(s_AccCe),
        .PcCe(s_PcCe), .IrCe(s_IrCe), .AccOe(s_AccOe), .MemRq(s_MemRq), .RnW(s_RnW),
        .Fetch(s_Fetch), .Halted(s_Halted), .InstrCount(s_InstrCount)
    );

    // {Fetch,Halted,XSel,YSel,AddrSel,M,AccCe,PcCe,IrCe,AccOe,MemRq,RnW}
    logic [12:0] got_vec, got_small_vec;
    assign got_vec = {Fetch, Halted, XSel, YSel, AddrSel, M, AccCe, PcCe, IrCe, AccOe, MemRq, RnW};
    assign got_small_vec = {s_Fetch, s_Halted, s_XSel, s_YSel, s_AddrSel, s_M, s_AccCe, s_PcCe,
                            s_IrCe, s_AccOe, s_MemRq, s_RnW};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] pack(input logic fe, ha, xs, ys, as, input logic [1:0] m,
                                         input logic ac, pc, ir, ao, rq, rw);
        return {fe, ha, xs, ys, as, m, ac, pc, ir, ao, rq, rw};
    endfunction

    // Expected control outputs from the instruction semantics of each phase.
    function automatic logic [12:0] exp_out(input int ph, input logic [3:0] op,
                                            input logic n, z, rdy);
        logic jump;
        if (ph == PH_F) return pack(1, 0, 1, 0, 0, 2'b10, 0, rdy, rdy, 0, 1, 1);
        if (ph == PH_H) return pack(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        jump = (op == 4'd4) || (op == 4'd5 && !n) || (op == 4'd6 && !z);
        case (op)
            4'd0: return pack(0, 0, 0, 0, 1, 2'b00, rdy, 0, 0, 0, 1, 1);
            4'd1: return pack(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 1, 0);
            4'd2: return pack(0, 0, 0, 0, 1, 2'b01, rdy, 0, 0, 0, 1, 1);
            4'd3: return pack(0, 0, 0, 0, 1, 2'b11, rdy, 0, 0, 0, 1, 1);
            default: return jump ? pack(0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0, 0, 0) : 13'd0;
        endcase
    endfunction

    task automatic check_counts();
        check("cnt", 32'(InstrCount), 32'(model_cnt));
        check("cnt4", 32'(s_InstrCount), 32'((model_cnt > 15) ? 15 : model_cnt));
    endtask

    task automatic step(input string tag, input int ph, input logic [3:0] op,
                        input logic n, z, rdy);
        logic [12:0] e;
        F = op; N = n; Z = z; MemReady = rdy;
        #4;
        e = exp_out(ph, op, n, z, rdy);
        check(tag, 32'(got_vec), 32'(e));
        check({tag, "_s"}, 32'(got_small_vec), 32'(e));
        check_counts();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic n, z, input int fw, ew);
        for (int i = 0; i < fw; i++) step("fetch_wait", PH_F, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        step("fetch", PH_F, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        if (op < 4'd4) begin
            for (int i = 0; i < ew; i++) step("exec_wait", PH_E, op, n, z, 1'b0);
            step("exec", PH_E, op, n, z, 1'b1);
        end else begin
            step("exec", PH_E, op, n, z, 1'($urandom));
        end
        model_cnt++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        F = 4'($urandom); N = 1'($urandom); Z = 1'($urandom); MemReady = 1'b1;
        #4;
        check("rst_out", 32'(got_vec), 32'd0);
        check("rst_cnt", 32'(InstrCount), 32'd0);
        check("rst_cnt4", 32'(s_InstrCount), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        Reset = 1'b1;
        F = 4'd0; N = 1'b0; Z = 1'b0; MemReady = 1'b0;
        #4;
        check("rst_out", 32'(got_vec), 32'd0);
        check("rst_cnt", 32'(InstrCount), 32'd0);
        @(posedge Clk);
        #1;
        do_reset();

        // Directed cases from the instruction set.
        run_instr(4'd0, 1'b0, 1'b0, 0, 0);
        run_instr(4'd1, 1'b0, 1'b0, 3, 0);
        run_instr(4'd5, 1'b1, 1'b0, 0, 0);
        run_instr(4'd5, 1'b0, 1'b1, 0, 0);
        run_instr(4'd6, 1'b0, 1'b1, 0, 0);
        run_instr(4'd6, 1'b1, 1'b0, 0, 0);
        run_instr(4'd3, 1'b0, 1'b0, 0, 2);
        run_instr(4'd9, 1'b1, 1'b1, 1, 0);
        run_instr(4'd4, 1'b1, 1'b1, 0, 0);

        // Twenty NOPs: the 4-bit instance must stop at 15.
        for (int i = 0; i < 20; i++) run_instr(4'(8 + (i % 8)), 1'($urandom), 1'($urandom), 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom);
            if (op == 4'd7) op = 4'd2;
            run_instr(op, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        run_instr(4'd7, 1'($urandom), 1'($urandom), 1, 0);
        for (int i = 0; i < 20; i++) step("halt", PH_H, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        do_reset();
        run_instr(4'd2, 1'b0, 1'b0, 0, 0);

        // Reset arriving in the middle of a stalled LDA.
        step("fetch", PH_F, 4'd0, 1'b0, 1'b0, 1'b1);
        F = 4'd0; MemReady = 1'b0;
        #2;
        check("mid_rq", 32'(MemRq), 32'd1);
        check("mid_acc", 32'(AccCe), 32'd0);
        #1;
        Reset = 1'b1;
        #1;
        check("mid_rst_out", 32'(got_vec), 32'd0);
        check("mid_rst_cnt", 32'(InstrCount), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_cnt = 0;
        run_instr(4'd0, 1'b0, 1'b0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
